// File: rtl/uart_word_assembler_pkg.sv
// rtl/uart_word_assembler_pkg.sv - shared defaults and derivations for the UART word assembler
package uart_word_assembler_pkg;

   localparam int BPS_DEFAULT          = 24;
   localparam int CLKS_PER_BIT_DEFAULT = 640;
   localparam int TIMEOUT_BITS_DEFAULT = 20;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_COLLECT = 1'b1
   } collect_state_t;

   function automatic int calc_bytes(input int bps);
      return bps / 8;
   endfunction

   function automatic int calc_timeout_clks(input int timeout_bits, input int clks_per_bit);
      return timeout_bits * clks_per_bit;
   endfunction

endpackage

// File: rtl/uart_word_out_slot.sv
// rtl/uart_word_out_slot.sv - one-entry valid/ready word holding register with overrun detection
module uart_word_out_slot
   import uart_word_assembler_pkg::*;
#(
   parameter int W = BPS_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic [W-1:0] data,
   output logic         valid,
   output logic         overrun
);

   logic accept;

   // A word may load into a slot that is draining in the same cycle.
   always_comb begin
      accept = load && (!valid || ready);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= load && !accept;
         if (accept) begin
            data  <= load_data;
            valid <= 1'b1;
         end else if (ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/uart_word_assembler.sv
// rtl/uart_word_assembler.sv - packs received UART bytes MSB-first into words with silence timeout
module uart_word_assembler
   import uart_word_assembler_pkg::*;
#(
   parameter int BPS          = BPS_DEFAULT,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEFAULT
) (
   input  logic           in_clk,
   input  logic           in_reset,
   input  logic [7:0]     in_byte,
   input  logic           in_byte_valid,
   output logic [BPS-1:0] out_word,
   output logic           out_valid,
   input  logic           in_ready,
   output logic           out_overrun,
   output logic           out_timeout,
   output logic           out_busy
);

   localparam int BYTES        = calc_bytes(BPS);
   localparam int TIMEOUT_CLKS = calc_timeout_clks(TIMEOUT_BITS, CLKS_PER_BIT);
   localparam int CNT_W        = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int TMR_W        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CLKS - 1);

   collect_state_t   state;
   logic [CNT_W-1:0] count, count_n;
   logic [TMR_W-1:0] timer, timer_n;
   logic [BPS-1:0]   shift, shift_n;
   logic [BPS-1:0]   assembled;
   logic             word_done;
   logic             expire;

   // Full-width shift keeps the BPS = 8 case legal: older bytes fall off the top.
   assign assembled = (shift << 8) | BPS'(in_byte);
   assign state     = (count == '0) ? ST_IDLE : ST_COLLECT;

   always_ff @(posedge in_clk or negedge in_reset) begin
      if (!in_reset) begin
         count       <= '0;
         shift       <= '0;
         timer       <= '0;
         out_timeout <= 1'b0;
      end else begin
         count       <= count_n;
         shift       <= shift_n;
         timer       <= timer_n;
         out_timeout <= expire;
      end
   end

   always_comb begin
      count_n   = count;
      shift_n   = shift;
      timer_n   = timer;
      word_done = 1'b0;
      expire    = 1'b0;
      if (in_byte_valid) begin
         // A strobe always beats a coincident timeout expiry.
         timer_n = '0;
         if (count == CNT_LAST) begin
            count_n   = '0;
            shift_n   = '0;
            word_done = 1'b1;
         end else begin
            count_n = count + 1'b1;
            shift_n = assembled;
         end
      end else if (state == ST_COLLECT) begin
         if (timer == TMR_LAST) begin
            count_n = '0;
            shift_n = '0;
            timer_n = '0;
            expire  = 1'b1;
         end else begin
            timer_n = timer + 1'b1;
         end
      end else begin
         timer_n = '0;
      end
   end

   always_comb begin
      out_busy = 1'b0;
      if (state == ST_COLLECT) begin
         out_busy = 1'b1;
      end
   end

   uart_word_out_slot #(
      .W(BPS)
   ) u_out_slot (
      .clk       (in_clk),
      .rst_n     (in_reset),
      .load      (word_done),
      .load_data (assembled),
      .ready     (in_ready),
      .data      (out_word),
      .valid     (out_valid),
      .overrun   (out_overrun)
   );

endmodule

// File: tb/tb_uart_word_assembler.sv
// tb/tb_uart_word_assembler.sv - self-checking bench for uart_word_assembler
module tb_uart_word_assembler;

   localparam int BPS          = 24;
   localparam int BYTES        = BPS / 8;
   localparam int TIMEOUT_CLKS = 20 * 640;

   logic           in_clk;
   logic           in_reset;
   logic [7:0]     in_byte;
   logic           in_byte_valid;
   logic [BPS-1:0] out_word;
   logic           out_valid;
   logic           in_ready;
   logic           out_overrun;
   logic           out_timeout;
   logic           out_busy;

   int checks = 0;
   int errors = 0;

   logic [7:0]     mq[$];
   int             idle;
   bit             m_valid;
   logic [BPS-1:0] m_word;
   bit             m_ovr;
   bit             m_tmo;

   uart_word_assembler dut (
      .in_clk        (in_clk),
      .in_reset      (in_reset),
      .in_byte       (in_byte),
      .in_byte_valid (in_byte_valid),
      .out_word      (out_word),
      .out_valid     (out_valid),
      .in_ready      (in_ready),
      .out_overrun   (out_overrun),
      .out_timeout   (out_timeout),
      .out_busy      (out_busy)
   );

   initial in_clk = 1'b0;
   always #5 in_clk = ~in_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      idle    = 0;
      m_valid = 0;
      m_word  = '0;
      m_ovr   = 0;
      m_tmo   = 0;
   endtask

   task automatic model_cycle(input bit v, input logic [7:0] b, input bit r);
      logic [BPS-1:0] w;
      bit keep;
      m_ovr = 0;
      m_tmo = 0;
      keep  = m_valid && !r;
      if (v) begin
         mq.push_back(b);
         idle = 0;
         if (mq.size() == BYTES) begin
            w = '0;
            foreach (mq[i]) w = (w << 8) | BPS'(mq[i]);
            mq.delete();
            if (keep) begin
               m_ovr = 1;
            end else begin
               keep   = 1;
               m_word = w;
            end
         end
      end else if (mq.size() != 0) begin
         idle++;
         if (idle == TIMEOUT_CLKS) begin
            mq.delete();
            idle  = 0;
            m_tmo = 1;
         end
      end
      m_valid = keep;
   endtask

   task automatic compare_all();
      check("valid", out_valid, m_valid);
      if (m_valid) check("word", out_word, m_word);
      check("overrun", out_overrun, m_ovr);
      check("timeout", out_timeout, m_tmo);
      check("busy", out_busy, mq.size() != 0);
   endtask

   task automatic step(input bit v, input logic [7:0] b, input bit r);
      @(negedge in_clk);
      in_byte_valid = v;
      in_byte       = b;
      in_ready      = r;
      model_cycle(v, b, r);
      @(posedge in_clk);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      @(negedge in_clk);
      in_reset      = 1'b0;
      in_byte_valid = 1'b0;
      #1;
      check("rst_word", out_word, 0);
      check("rst_valid", out_valid, 0);
      check("rst_overrun", out_overrun, 0);
      check("rst_timeout", out_timeout, 0);
      check("rst_busy", out_busy, 0);
      model_reset();
      @(negedge in_clk);
      in_reset = 1'b1;
   endtask

   initial begin
      in_reset      = 1'b0;
      in_byte       = 8'h00;
      in_byte_valid = 1'b0;
      in_ready      = 1'b0;
      do_reset();

      // Basic word with consumer ready
      step(1, 8'h3F, 1);
      step(1, 8'h03, 1);
      step(1, 8'h33, 1);
      check("basic_word", out_word, 24'h3F0333);
      check("basic_valid", out_valid, 1);
      step(0, 8'h00, 1);
      check("basic_drain", out_valid, 0);

      // Overrun while slot is full
      step(1, 8'hFF, 0);
      step(1, 8'hE4, 0);
      step(1, 8'hB7, 0);
      step(1, 8'hA9, 0);
      step(1, 8'hB1, 0);
      step(1, 8'hC5, 0);
      check("ovr_pulse", out_overrun, 1);
      check("ovr_held", out_word, 24'hFFE4B7);
      step(0, 8'h00, 1);
      check("ovr_gone", out_valid, 0);

      // Partial word discarded after silence
      step(1, 8'hF1, 1);
      step(1, 8'h1F, 1);
      for (int i = 0; i < TIMEOUT_CLKS; i++) step(0, 8'h00, 1);
      check("tmo_pulse", out_timeout, 1);
      check("tmo_busy", out_busy, 0);
      step(1, 8'hAA, 1);
      step(1, 8'hBB, 1);
      step(1, 8'hCC, 1);
      check("after_tmo_word", out_word, 24'hAABBCC);
      step(0, 8'h00, 1);

      // Final strobe coincides with draining the full slot
      step(1, 8'h11, 0);
      step(1, 8'h22, 0);
      step(1, 8'h33, 0);
      step(1, 8'h12, 0);
      step(1, 8'h34, 0);
      step(1, 8'h56, 1);
      check("pass_word", out_word, 24'h123456);
      check("pass_valid", out_valid, 1);
      check("pass_no_ovr", out_overrun, 0);
      step(0, 8'h00, 1);

      // Strobe lands exactly on the expiry cycle
      step(1, 8'h01, 1);
      for (int i = 0; i < TIMEOUT_CLKS - 1; i++) step(0, 8'h00, 1);
      step(1, 8'h02, 1);
      check("edge_no_tmo", out_timeout, 0);
      check("edge_busy", out_busy, 1);
      step(1, 8'h03, 1);
      check("edge_word", out_word, 24'h010203);
      step(0, 8'h00, 1);

      // Reset with a held word and a partial word
      step(1, 8'h77, 0);
      step(1, 8'h88, 0);
      step(1, 8'h99, 0);
      step(1, 8'h3F, 0);
      step(1, 8'h03, 0);
      do_reset();
      step(1, 8'h3F, 1);
      step(1, 8'h03, 1);
      step(1, 8'h33, 1);
      check("post_rst_word", out_word, 24'h3F0333);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0);
      end
      step(0, 8'h00, 1);
      step(0, 8'h00, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_word_assembler.md
Name: uart_word_assembler

Overview:
- Sits directly downstream of the UART byte receiver and upstream of the sample-processing/TX path inside main.
- Packs BPS/8 consecutive received bytes, most significant byte first, into one BPS-bit word.
- Presents each completed word on a one-entry valid/ready output slot.
- Discards partial words after an inter-byte silence timeout, so a dropped byte cannot permanently misalign framing.

Parameters:
- BPS, 24, output word width in bits; must be a multiple of 8 and at least 8.
- CLKS_PER_BIT, 640, UART bit period in clocks (73.728 MHz clock).
- TIMEOUT_BITS, 20, inter-byte silence in bit periods before a partial word is discarded.
- Derived localparams: BYTES = BPS/8; TIMEOUT_CLKS = TIMEOUT_BITS*CLKS_PER_BIT.

Ports:
- in_clk  input  1  system clock; single clock domain.
- in_reset  input  1  asynchronous, active-low reset.
- in_byte  input  8  received byte from the UART receiver.
- in_byte_valid  input  1  one-cycle strobe; in_byte is valid this cycle.
- out_word  output  BPS  assembled word; first received byte occupies bits [BPS-1:BPS-8].
- out_valid  output  1  output slot holds a word.
- in_ready  input  1  consumer accepts the word; transfer occurs when out_valid && in_ready.
- out_overrun  output  1  one-cycle pulse: completed word dropped because the slot was full.
- out_timeout  output  1  one-cycle pulse: partial word discarded by timeout.
- out_busy  output  1  high while a partial word is being collected (byte count != 0).

Behaviour:
- Reset (async assert, sync-safe release):
  - Clears out_word, out_valid, out_overrun, out_timeout and out_busy to 0.
  - Clears the byte counter, shift register and timeout counter.
- Collector states:
  - IDLE (count = 0).
  - COLLECT (1 <= count <= BYTES-1).
  - The output slot is independent of the collector state.
- Byte strobe with count < BYTES-1:
  - Shift register <= {shift[BPS-9:0], in_byte}.
  - count increments; timeout counter clears.
- Byte strobe with count = BYTES-1 (word completes):
  - If the slot is empty, or is draining this same cycle (out_valid && in_ready), out_word <= {shift[BPS-9:0], in_byte} and out_valid = 1 on the next cycle. Latency is 1 clock from the final byte strobe.
  - Otherwise the word is dropped, out_word is unchanged, and out_overrun pulses for 1 cycle.
  - In both cases count returns to 0 (IDLE).
- Output slot:
  - out_word is stable while out_valid = 1 and no transfer has occurred.
  - A transfer clears out_valid on the next cycle unless a new word loads in the same cycle.
- Timeout:
  - In COLLECT, the timeout counter increments every clock without a byte strobe.
  - On reaching TIMEOUT_CLKS-1: count returns to 0, the shift register clears, out_timeout pulses for 1 cycle, and the counter clears.
  - The counter is held at 0 in IDLE; an output slot that stays full never triggers a timeout.
  - If a byte strobe and timeout expiry coincide, the byte wins: it is shifted in, the timer clears, and no timeout pulse is produced.
- BPS = 8: every byte strobe completes a word; COLLECT and the timeout are never entered.
- Reset mid-word or mid-hold: the partial word and the held word are both lost, with no pulses.
- All counters are sized with $clog2; no wrap-around is reachable.

Decomposition:
- Shared package/header (shared with main):
  - BPS default and CLKS_PER_BIT default.
  - BYTES and TIMEOUT_CLKS derivation macros.
- One sub-module: uart_word_out_slot, the one-entry valid/ready holding register with the overrun decision.
- Collector, counter and timeout logic stay in the top module.

Test Plan:
- Bytes 3F, 03, 33 with in_ready = 1:
  - out_word = 24'h3F0333, out_valid high exactly 1 cycle, starting 1 clock after the third strobe.
  - out_busy high from the first strobe until the third.
- in_ready = 0; send FF, E4, B7 then A9, B1, C5:
  - out_word holds 24'hFFE4B7; out_overrun pulses once at the sixth strobe.
  - Raising in_ready transfers FFE4B7 only.
- Send F1, 1F, then 12800 idle clocks:
  - out_timeout pulses once; out_busy falls; no word is produced.
  - Then AA, BB, CC gives out_word = 24'hAABBCC.
- Slot full with the third byte strobe in the same cycle as in_ready = 1:
  - Old word transfers, the new word 24'h123456 loads, out_valid stays high, and there is no overrun.
- Byte strobe exactly on timeout cycle 12799:
  - No timeout pulse; the next byte completes the word correctly.
- Assert in_reset low after 2 bytes of a word:
  - All outputs go to 0 immediately.
  - After release, 3F, 03, 33 yields 24'h3F0333.
